rx_seq_os_detect: RTL and testbench

// - Receive-side sequence ordered-set decoder, directly upstream of the link-fault state machine.
// - Inspects each 32-bit XGMII column on rxclk_2x and flags local-fault and remote-fault sequence columns.
// - Its local_fault/remote_fault outputs drive the link-fault state machine's inputs directly.
// - Also keeps per-type event counters and a fault-activity status for management reads.

---
 rtl/rx_seq_os_detect.sv | 68 ++++++
 tb/tb_rx_seq_os_detect.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rx_seq_os_detect.sv
// rx_seq_os_detect: flags XGMII local/remote/reserved sequence columns, counts them, and reports recent sequence activity.
module rx_seq_os_detect #(
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_COLS = 128
) (
  input  logic             rxclk_2x,
  input  logic             reset_n,
  input  logic [31:0]      rxd,
  input  logic [3:0]       rxc,
  input  logic             col_valid,
  input  logic             cnt_clear,
  output logic             local_fault,
  output logic             remote_fault,
  output logic             seq_reserved,
  output logic             seq_active,
  output logic [CNT_W-1:0] local_cnt,
  output logic [CNT_W-1:0] remote_cnt,
  output logic [CNT_W-1:0] reserved_cnt
);
  localparam int IW = $clog2(TIMEOUT_COLS) + 1;
  localparam logic [IW-1:0] DROP_AT = IW'(TIMEOUT_COLS - 2);
  typedef enum logic {QUIET, ACTIVE} state_t;
  state_t state;
  logic [IW-1:0] idle_cnt;
  logic [31:0] d1;
  logic [3:0] c1;
  logic v1, seq, is_loc, is_rem, is_res;
  assign seq    = c1 == 4'b0001 && d1[23:0] == 24'h00009C;
  assign is_loc = seq && d1[31:24] == 8'h01;
  assign is_rem = seq && d1[31:24] == 8'h02;
  assign is_res = seq && !is_loc && !is_rem;
  assign seq_active = state == ACTIVE;
  always_ff @(posedge rxclk_2x or negedge reset_n) begin
    if (!reset_n) begin
      d1           <= '0;
      c1           <= '0;
      v1           <= 1'b0;
      local_fault  <= 1'b0;
      remote_fault <= 1'b0;
      seq_reserved <= 1'b0;
      local_cnt    <= '0;
      remote_cnt   <= '0;
      reserved_cnt <= '0;
      state        <= QUIET;
      idle_cnt     <= '0;
    end else begin
      d1 <= rxd;
      c1 <= rxc;
      v1 <= col_valid;
      if (v1) begin
        local_fault  <= is_loc;
        remote_fault <= is_rem;
        seq_reserved <= is_res;
      end
      local_cnt    <= cnt_clear ? '0 : local_cnt + CNT_W'(v1 && is_loc && !(&local_cnt));
      remote_cnt   <= cnt_clear ? '0 : remote_cnt + CNT_W'(v1 && is_rem && !(&remote_cnt));
      reserved_cnt <= cnt_clear ? '0 : reserved_cnt + CNT_W'(v1 && is_res && !(&reserved_cnt));
      // idle_cnt about to reach TIMEOUT_COLS-1 means this idle column ends the active window
      if (v1 && seq) begin
        state    <= ACTIVE;
        idle_cnt <= '0;
      end else if (v1 && state == ACTIVE) begin
        state    <= idle_cnt == DROP_AT ? QUIET : ACTIVE;
        idle_cnt <= idle_cnt == DROP_AT ? '0 : idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rx_seq_os_detect.sv
// tb_rx_seq_os_detect: directed and random checks of rx_seq_os_detect against a column-level reference model.
module tb_rx_seq_os_detect;
  localparam int TO = 128;
  localparam int MAXC = 65535;
  localparam logic [31:0] LOC = 32'h0100009C, REM = 32'h0200009C, RSV = 32'h0700009C, IDLE = 32'h07070707;
  logic clk = 0, reset_n = 0, col_valid = 0, cnt_clear = 0;
  logic [31:0] rxd = '0;
  logic [3:0] rxc = '0;
  logic local_fault, remote_fault, seq_reserved, seq_active;
  logic [15:0] local_cnt, remote_cnt, reserved_cnt;
  int compared = 0, mismatched = 0;
  int m_loc, m_rem, m_res, run;
  bit m_lf, m_rf, m_sr, seen, p_v;
  int p_t;

  rx_seq_os_detect #(.CNT_W(16), .TIMEOUT_COLS(TO)) dut (
    .rxclk_2x(clk), .reset_n(reset_n), .rxd(rxd), .rxc(rxc), .col_valid(col_valid),
    .cnt_clear(cnt_clear), .local_fault(local_fault), .remote_fault(remote_fault),
    .seq_reserved(seq_reserved), .seq_active(seq_active), .local_cnt(local_cnt),
    .remote_cnt(remote_cnt), .reserved_cnt(reserved_cnt));

  always #5 clk = ~clk;

  function automatic int typ(input logic [31:0] d, input logic [3:0] c);
    if (c != 4'd1 || d[23:0] != 24'h00009C) return 0;
    return d[31:24] == 8'h01 ? 1 : d[31:24] == 8'h02 ? 2 : 3;
  endfunction

  function automatic int sat(input int v);
    return v >= MAXC ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    m_loc = 0; m_rem = 0; m_res = 0; run = 0;
    m_lf = 0; m_rf = 0; m_sr = 0; seen = 0; p_v = 0; p_t = 0;
  endtask

  // effects of one clock edge: the previously presented column lands, clear overrides its count
  task automatic model_edge(input bit clr, input bit v, input int t);
    if (p_v) begin
      m_lf = p_t == 1; m_rf = p_t == 2; m_sr = p_t == 3;
      if (p_t != 0) begin seen = 1; run = 0; end
      else if (seen) begin
        run++;
        if (run == TO - 1) begin seen = 0; run = 0; end
      end
      if (p_t == 1) m_loc = sat(m_loc);
      if (p_t == 2) m_rem = sat(m_rem);
      if (p_t == 3) m_res = sat(m_res);
    end
    if (clr) begin m_loc = 0; m_rem = 0; m_res = 0; end
    p_v = v; p_t = t;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".local_fault"}, 32'(local_fault), 32'(m_lf));
    chk({tag, ".remote_fault"}, 32'(remote_fault), 32'(m_rf));
    chk({tag, ".seq_reserved"}, 32'(seq_reserved), 32'(m_sr));
    chk({tag, ".seq_active"}, 32'(seq_active), 32'(seen));
    chk({tag, ".local_cnt"}, 32'(local_cnt), 32'(m_loc));
    chk({tag, ".remote_cnt"}, 32'(remote_cnt), 32'(m_rem));
    chk({tag, ".reserved_cnt"}, 32'(reserved_cnt), 32'(m_res));
  endtask

  task automatic step(input string tag, input logic [31:0] d, input logic [3:0] c, input bit v, input bit clr);
    rxd = d; rxc = c; col_valid = v; cnt_clear = clr;
    @(posedge clk);
    model_edge(clr, v, typ(d, c));
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 0;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic rand_col(output logic [31:0] d, output logic [3:0] c);
    int k = $urandom_range(0, 7);
    d = k == 0 ? LOC : k == 1 ? REM : k == 2 ? {8'($urandom), 24'h00009C} :
        k == 3 ? {8'($urandom), 8'($urandom_range(0, 1)), 16'h009C} : k == 4 ? IDLE : $urandom;
    c = $urandom_range(0, 3) == 0 ? 4'($urandom) : (k == 4 ? 4'hF : 4'h1);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0] c;
    @(negedge clk);
    do_reset("reset");
    for (int i = 0; i < 4; i++) step("local4", LOC, 4'h1, 1, 0);
    step("flush", IDLE, 4'hF, 0, 0);
    step("flush", IDLE, 4'hF, 0, 0);
    chk("local_cnt_is_4", 32'(local_cnt), 32'd4);
    chk("local_flag_held", 32'(local_fault), 32'd1);
    for (int i = 0; i < 3; i++) step("remote3", REM, 4'h1, 1, 0);
    step("reserved", RSV, 4'h1, 1, 0);
    step("flush", IDLE, 4'hF, 0, 0);
    step("flush", IDLE, 4'hF, 0, 0);
    chk("remote_cnt_is_3", 32'(remote_cnt), 32'd3);
    chk("reserved_cnt_is_1", 32'(reserved_cnt), 32'd1);
    step("bad_rxc", LOC, 4'h3, 1, 0);
    step("bad_lane1", 32'h0100019C, 4'h1, 1, 0);
    step("bad_flush", IDLE, 4'hF, 0, 0);
    chk("bad_no_flag", 32'({local_fault, remote_fault, seq_reserved}), 32'd0);
    chk("bad_local_cnt", 32'(local_cnt), 32'd4);
    step("to_seed", LOC, 4'h1, 1, 0);
    for (int i = 0; i < TO + 2; i++) step("timeout", IDLE, 4'hF, 1, 0);
    chk("timeout_dropped", 32'(seq_active), 32'd0);
    step("gap_seed", LOC, 4'h1, 1, 0);
    for (int i = 0; i < TO + 2; i++) begin
      step("gap_idle", IDLE, 4'hF, 1, 0);
      for (int j = $urandom_range(0, 2); j > 0; j--) step("gap_hole", $urandom, 4'($urandom), 0, 0);
    end
    chk("gap_dropped", 32'(seq_active), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      rand_col(d, c);
      step("random", d, c, $urandom_range(0, 4) != 0, $urandom_range(0, 60) == 0);
    end
    step("sat_clear", IDLE, 4'hF, 0, 1);
    for (int i = 0; i < MAXC; i++) step("sat_fill", LOC, 4'h1, 1, 0);
    step("sat_more", LOC, 4'h1, 1, 0);
    step("sat_flush", IDLE, 4'hF, 0, 0);
    chk("sat_hold", 32'(local_cnt), 32'hFFFF);
    step("clr_col", LOC, 4'h1, 1, 0);
    step("clr_edge", IDLE, 4'hF, 0, 1);
    chk("clear_wins", 32'(local_cnt), 32'd0);
    step("pre_rst", REM, 4'h1, 1, 0);
    step("pre_rst", LOC, 4'h1, 1, 0);
    step("pre_rst", LOC, 4'h1, 1, 0);
    chk("pre_rst_active", 32'(seq_active), 32'd1);
    #2;
    do_reset("midreset");
    step("post_rst", RSV, 4'h1, 1, 0);
    step("post_rst", IDLE, 4'hF, 1, 0);
    chk("post_rst_decode", 32'(seq_reserved), 32'd1);
    for (int i = 0; i < 200; i++) begin
      rand_col(d, c);
      step("random2", d, c, $urandom_range(0, 3) != 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
